// File: rtl/mdu_pkg.sv
// mdu_pkg: divider FSM states, W-op iteration count and M-extension divide op encodings
package mdu_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;
    localparam int MDU_DIV_W_ITERS = 32;
    localparam logic [2:0] MDU_OP_DIV  = 3'b100;
    localparam logic [2:0] MDU_OP_DIVU = 3'b101;
    localparam logic [2:0] MDU_OP_REM  = 3'b110;
    localparam logic [2:0] MDU_OP_REMU = 3'b111;
endpackage

// File: rtl/mdu_div_prep.sv
// mdu_div_prep: W-extension, operand magnitudes, sign flags and special-case results
module mdu_div_prep #(
    parameter int XLEN = 64
) (
    input  logic            sgn,
    input  logic            word,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] a_mag,
    output logic [XLEN-1:0] b_mag,
    output logic            q_neg,
    output logic            r_neg,
    output logic            special,
    output logic [XLEN-1:0] spec_q,
    output logic [XLEN-1:0] spec_r
);
    logic [XLEN-1:0] a_x, b_x, min_n;
    logic            a_s, b_s, b_zero, ovf;
    always_comb begin
        a_x     = word ? (sgn ? XLEN'($signed(a[31:0])) : XLEN'(a[31:0])) : a;
        b_x     = word ? (sgn ? XLEN'($signed(b[31:0])) : XLEN'(b[31:0])) : b;
        a_s     = sgn & a_x[XLEN-1];
        b_s     = sgn & b_x[XLEN-1];
        a_mag   = a_s ? -a_x : a_x;
        b_mag   = b_s ? -b_x : b_x;
        b_zero  = b_x == '0;
        min_n   = word ? ~XLEN'(32'h7fff_ffff) : {1'b1, {(XLEN-1){1'b0}}};
        ovf     = sgn & (a_x == min_n) & (b_x == '1);
        special = b_zero | ovf;
        q_neg   = (a_s ^ b_s) & ~b_zero;
        r_neg   = a_s;
        // |MIN| wraps to MIN, which is exactly the overflow quotient; -|a| restores a for b==0
        spec_q  = b_zero ? '1 : a_mag;
        spec_r  = b_zero ? a_mag : '0;
    end
endmodule

// File: rtl/mdu_div_iter.sv
// mdu_div_iter: iterative radix-2 restoring divider (DIV/DIVU/REM/REMU and W variants)
module mdu_div_iter
    import mdu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int TAG_W  = 5,
    parameter int CTRL_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_signed,
    input  logic              in_word,
    input  logic              in_rem,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [XLEN-1:0]   in_a,
    input  logic [XLEN-1:0]   in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              busy
);
    localparam int CW = $clog2(XLEN);
    mdu_state_e      state;
    logic [CW-1:0]   cnt;
    logic [XLEN-1:0] q, r, b_r, q_nxt, r_nxt;
    logic [XLEN-1:0] a_mag, b_mag, spec_q, spec_r;
    logic [XLEN:0]   r_sh;
    logic            q_neg, r_neg, rem, w, word, p_qneg, p_rneg, special, ge, last;

    function automatic logic [XLEN-1:0] fin(input logic [XLEN-1:0] qv, rv, input logic qn, rn, rm, wd);
        logic [XLEN-1:0] v;
        v = rm ? (rn ? -rv : rv) : (qn ? -qv : qv);
        return wd ? XLEN'($signed(v[31:0])) : v;
    endfunction

    assign word     = in_word & (XLEN == 64);
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;

    mdu_div_prep #(.XLEN(XLEN)) u_prep (
        .sgn    (in_signed),
        .word   (word),
        .a      (in_a),
        .b      (in_b),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .q_neg  (p_qneg),
        .r_neg  (p_rneg),
        .special(special),
        .spec_q (spec_q),
        .spec_r (spec_r)
    );

    // q doubles as the dividend shift register: dividend bits leave the top as quotient bits enter the bottom
    always_comb begin
        r_sh  = {r, q[XLEN-1]};
        ge    = r_sh >= {1'b0, b_r};
        r_nxt = ge ? XLEN'(r_sh - {1'b0, b_r}) : r_sh[XLEN-1:0];
        q_nxt = {q[XLEN-2:0], ge};
        last  = cnt == CW'((w ? MDU_DIV_W_ITERS : XLEN) - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            q          <= '0;
            r          <= '0;
            b_r        <= '0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            rem        <= 1'b0;
            w          <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_ctrl   <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    out_tag  <= in_tag;
                    out_ctrl <= in_ctrl;
                    q        <= word ? a_mag << (XLEN - MDU_DIV_W_ITERS) : a_mag;
                    r        <= '0;
                    b_r      <= b_mag;
                    q_neg    <= p_qneg;
                    r_neg    <= p_rneg;
                    rem      <= in_rem;
                    w        <= word;
                    cnt      <= '0;
                    if (special) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= fin(spec_q, spec_r, p_qneg, p_rneg, in_rem, word);
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    q   <= q_nxt;
                    r   <= r_nxt;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out_result <= fin(q_nxt, r_nxt, q_neg, r_neg, rem, w);
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
